// File: rtl/systolic_array_feeder_if.sv
// Upstream handshakes into the systolic array feeder: weight rows and input vectors.
// The producer side uses the master modport, the feeder uses the slave modport.
interface systolic_array_feeder_if #(
    parameter int unsigned BitSize     = 8,
    parameter int unsigned M_W_BitSize = 8,
    parameter int unsigned NumOfInputs = 2,
    parameter int unsigned NumOfNerves = 3
);
    logic                               w_valid;
    logic                               w_ready;
    logic [NumOfNerves*M_W_BitSize-1:0] w_row;
    logic                               x_valid;
    logic                               x_ready;
    logic [NumOfInputs*BitSize-1:0]     x_vec;
    logic                               x_last;

    modport master (
        output w_valid, w_row, x_valid, x_vec, x_last,
        input  w_ready, x_ready
    );

    modport slave (
        input  w_valid, w_row, x_valid, x_vec, x_last,
        output w_ready, x_ready
    );
endinterface

// File: rtl/systolic_array_feeder.sv
// Loads weight rows into a systolic array and streams input vectors into it.
// Each vector is diagonally skewed so that lane i reaches the array i cycles after lane 0.
module systolic_array_feeder #(
    parameter int unsigned BitSize     = 8,
    parameter int unsigned M_W_BitSize = 8,
    parameter int unsigned NumOfInputs = 2,
    parameter int unsigned NumOfNerves = 3
) (
    input  logic                               clk_i,
    input  logic                               res_i,
    systolic_array_feeder_if.slave             up_if,
    output logic [NumOfNerves*M_W_BitSize-1:0] sa_weights_o,
    output logic                               sa_en_l_b_o,
    output logic                               sa_in_valid_o,
    output logic                               sa_in_start_o,
    output logic [NumOfInputs*BitSize-1:0]     sa_in_data_o,
    output logic                               busy_o
);
    localparam int unsigned CntW        = $clog2(NumOfInputs + 1);
    localparam int unsigned FlushCycles = (NumOfInputs > 1) ? NumOfInputs - 1 : 1;
    localparam logic [CntW-1:0] LastRow   = CntW'(NumOfInputs - 1);
    localparam logic [CntW-1:0] FlushLast = CntW'(FlushCycles - 1);

    typedef enum logic [1:0] {StIdle, StLoadW, StStream, StFlush} state_e;

    state_e                             state_q;
    logic                               w_loaded_q;
    logic [CntW-1:0]                    cnt_q;
    logic [NumOfNerves*M_W_BitSize-1:0] weights_q;
    logic                               en_q;
    logic                               start_q;

    logic                               w_xfer;
    logic                               x_xfer;
    logic [NumOfInputs-1:0]             lane_valid;
    logic [NumOfInputs-1:0]             lane_any;

    // A pending weight row in IDLE masks x_ready so the weight always wins without a lost vector.
    assign up_if.w_ready = (state_q == StIdle) || (state_q == StLoadW);
    assign up_if.x_ready = (state_q == StStream) ||
                           ((state_q == StIdle) && w_loaded_q && !up_if.w_valid);

    assign w_xfer = up_if.w_valid && up_if.w_ready;
    assign x_xfer = up_if.x_valid && up_if.x_ready;

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            state_q    <= StIdle;
            w_loaded_q <= 1'b0;
            cnt_q      <= '0;
            weights_q  <= '0;
            en_q       <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            en_q    <= w_xfer;
            start_q <= x_xfer && (state_q == StIdle);
            if (w_xfer) begin
                weights_q <= up_if.w_row;
            end
            unique case (state_q)
                StIdle: begin
                    if (w_xfer) begin
                        if (NumOfInputs == 1) begin
                            w_loaded_q <= 1'b1;
                        end else begin
                            state_q    <= StLoadW;
                            w_loaded_q <= 1'b0;
                            cnt_q      <= CntW'(1);
                        end
                    end else if (x_xfer) begin
                        // A single-vector batch skips STREAM and drains straight away.
                        if (!up_if.x_last) begin
                            state_q <= StStream;
                        end else if (NumOfInputs > 1) begin
                            state_q <= StFlush;
                            cnt_q   <= '0;
                        end
                    end
                end
                StLoadW: begin
                    if (w_xfer) begin
                        if (cnt_q == LastRow) begin
                            w_loaded_q <= 1'b1;
                            state_q    <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StStream: begin
                    if (x_xfer && up_if.x_last) begin
                        if (NumOfInputs == 1) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StFlush;
                            cnt_q   <= '0;
                        end
                    end
                end
                StFlush: begin
                    if (cnt_q == FlushLast) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Lane i owns i+1 stages: the common output register plus i skew stages.
    for (genvar i = 0; i < NumOfInputs; i++) begin : g_lane
        logic [BitSize-1:0] data_q [i+1];
        logic [i:0]         vld_q;

        always_ff @(posedge clk_i or posedge res_i) begin
            if (res_i) begin
                vld_q <= '0;
                for (int k = 0; k <= i; k++) begin
                    data_q[k] <= '0;
                end
            end else begin
                vld_q[0]  <= x_xfer;
                data_q[0] <= x_xfer ? up_if.x_vec[i*BitSize +: BitSize] : '0;
                for (int k = 1; k <= i; k++) begin
                    vld_q[k]  <= vld_q[k-1];
                    data_q[k] <= data_q[k-1];
                end
            end
        end

        assign sa_in_data_o[i*BitSize +: BitSize] = data_q[i];
        assign lane_valid[i]                      = vld_q[i];
        assign lane_any[i]                        = |vld_q;
    end

    assign sa_weights_o  = weights_q;
    assign sa_en_l_b_o   = en_q;
    assign sa_in_start_o = start_q;
    assign sa_in_valid_o = |lane_valid;
    assign busy_o        = (state_q != StIdle) || (|lane_any);
endmodule

// File: tb/tb_systolic_array_feeder.sv
// Directed bench for systolic_array_feeder: reset, weight load, skewed stream, bubble,
// weight/vector priority and reset in the middle of a stream.
module tb_systolic_array_feeder;
    localparam int unsigned BitSize     = 8;
    localparam int unsigned M_W_BitSize = 8;
    localparam int unsigned NumOfInputs = 2;
    localparam int unsigned NumOfNerves = 3;

    logic        clk;
    logic        res;
    logic [23:0] sa_weights;
    logic        sa_en_l_b;
    logic        sa_in_valid;
    logic        sa_in_start;
    logic [15:0] sa_in_data;
    logic        busy;

    int n_cmp;
    int n_err;

    systolic_array_feeder_if #(
        .BitSize    (BitSize),
        .M_W_BitSize(M_W_BitSize),
        .NumOfInputs(NumOfInputs),
        .NumOfNerves(NumOfNerves)
    ) up_if ();

    systolic_array_feeder #(
        .BitSize    (BitSize),
        .M_W_BitSize(M_W_BitSize),
        .NumOfInputs(NumOfInputs),
        .NumOfNerves(NumOfNerves)
    ) dut (
        .clk_i        (clk),
        .res_i        (res),
        .up_if        (up_if),
        .sa_weights_o (sa_weights),
        .sa_en_l_b_o  (sa_en_l_b),
        .sa_in_valid_o(sa_in_valid),
        .sa_in_start_o(sa_in_start),
        .sa_in_data_o (sa_in_data),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_w(input logic v, input logic [23:0] row);
        up_if.w_valid = v;
        up_if.w_row   = row;
    endtask

    task automatic drive_x(input logic v, input logic [15:0] vec, input logic last);
        up_if.x_valid = v;
        up_if.x_vec   = vec;
        up_if.x_last  = last;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        res   = 1'b1;
        drive_w(1'b0, 24'h0);
        drive_x(1'b0, 16'h0, 1'b0);
        tick();
        tick();
        res = 1'b0;
        #1;

        // Reset state
        check_eq("rst_w_ready", up_if.w_ready, 1);
        check_eq("rst_x_ready", up_if.x_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", sa_in_valid, 0);
        check_eq("rst_en", sa_en_l_b, 0);
        check_eq("rst_weights", sa_weights, 0);

        // Vector offered before any load is refused
        drive_x(1'b1, 16'h0607, 1'b0);
        #1;
        check_eq("guard_x_ready", up_if.x_ready, 0);
        tick();
        tick();
        check_eq("guard_valid", sa_in_valid, 0);
        check_eq("guard_busy", busy, 0);
        drive_x(1'b0, 16'h0, 1'b0);

        // Weight load, two rows back to back
        drive_w(1'b1, 24'h010001);
        tick();
        check_eq("wl_en0", sa_en_l_b, 1);
        check_eq("wl_row0", sa_weights, 24'h010001);
        check_eq("wl_x_ready_mid", up_if.x_ready, 0);
        drive_w(1'b1, 24'h010101);
        tick();
        check_eq("wl_en1", sa_en_l_b, 1);
        check_eq("wl_row1", sa_weights, 24'h010101);
        drive_w(1'b0, 24'h0);
        #1;
        check_eq("wl_x_ready", up_if.x_ready, 1);
        tick();
        check_eq("wl_en_off", sa_en_l_b, 0);
        check_eq("wl_hold", sa_weights, 24'h010101);

        // Skewed stream: v0 then v1 with x_last
        drive_x(1'b1, 16'h0607, 1'b0);
        tick();
        check_eq("sk_d1", sa_in_data, 16'h0007);
        check_eq("sk_s1", sa_in_start, 1);
        check_eq("sk_v1", sa_in_valid, 1);
        drive_x(1'b1, 16'h0005, 1'b1);
        tick();
        check_eq("sk_d2", sa_in_data, 16'h0605);
        check_eq("sk_s2", sa_in_start, 0);
        check_eq("sk_v2", sa_in_valid, 1);
        drive_x(1'b0, 16'h0, 1'b0);
        #1;
        check_eq("sk_flush_x_ready", up_if.x_ready, 0);
        tick();
        check_eq("sk_d3", sa_in_data, 16'h0000);
        check_eq("sk_v3", sa_in_valid, 1);
        check_eq("sk_busy3", busy, 1);
        tick();
        check_eq("sk_v4", sa_in_valid, 0);
        check_eq("sk_busy4", busy, 0);
        check_eq("sk_idle_x_ready", up_if.x_ready, 1);

        // Bubble between v0 and v1
        drive_x(1'b1, 16'h0607, 1'b0);
        tick();
        check_eq("bb_d1", sa_in_data, 16'h0007);
        check_eq("bb_s1", sa_in_start, 1);
        drive_x(1'b0, 16'h0, 1'b0);
        tick();
        check_eq("bb_d2", sa_in_data, 16'h0600);
        check_eq("bb_v2", sa_in_valid, 1);
        check_eq("bb_s2", sa_in_start, 0);
        drive_x(1'b1, 16'h0005, 1'b1);
        tick();
        check_eq("bb_d3", sa_in_data, 16'h0005);
        check_eq("bb_v3", sa_in_valid, 1);
        check_eq("bb_s3", sa_in_start, 0);
        drive_x(1'b0, 16'h0, 1'b0);
        tick();
        check_eq("bb_v4", sa_in_valid, 1);
        check_eq("bb_s4", sa_in_start, 0);
        tick();
        check_eq("bb_v5", sa_in_valid, 0);

        // Simultaneous weight and vector in IDLE: weight wins, vector refused
        drive_w(1'b1, 24'h030201);
        drive_x(1'b1, 16'h0909, 1'b0);
        #1;
        check_eq("pr_x_ready", up_if.x_ready, 0);
        check_eq("pr_w_ready", up_if.w_ready, 1);
        tick();
        check_eq("pr_en0", sa_en_l_b, 1);
        check_eq("pr_row0", sa_weights, 24'h030201);
        check_eq("pr_valid0", sa_in_valid, 0);
        check_eq("pr_x_ready_lw", up_if.x_ready, 0);
        drive_w(1'b1, 24'h060504);
        drive_x(1'b0, 16'h0, 1'b0);
        tick();
        check_eq("pr_row1", sa_weights, 24'h060504);
        check_eq("pr_valid1", sa_in_valid, 0);
        drive_w(1'b0, 24'h0);
        tick();

        // Reset in the middle of a stream
        drive_x(1'b1, 16'h0B0A, 1'b0);
        tick();
        check_eq("rs_d1", sa_in_data, 16'h000A);
        drive_x(1'b1, 16'h0D0C, 1'b0);
        tick();
        check_eq("rs_d2", sa_in_data, 16'h0B0C);
        #2;
        res = 1'b1;
        #1;
        check_eq("rs_data", sa_in_data, 16'h0000);
        check_eq("rs_valid", sa_in_valid, 0);
        check_eq("rs_busy", busy, 0);
        check_eq("rs_w_ready", up_if.w_ready, 1);
        check_eq("rs_x_ready", up_if.x_ready, 0);
        #2;
        res = 1'b0;
        tick();
        check_eq("rs_post_x_ready", up_if.x_ready, 0);
        check_eq("rs_post_valid", sa_in_valid, 0);
        check_eq("rs_post_busy", busy, 0);
        drive_x(1'b0, 16'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
